// File: rtl/wb_master_cmd.sv
// Wishbone classic master: one bus cycle per valid/ready command, one response per
// command, with an optional bus timeout so a silent slave cannot stall the initiator.
module wb_master_cmd #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_data,
    input  logic [SELECT_WIDTH-1:0] cmd_sel,
    input  logic                    cmd_we,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,

    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,

    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic                    wb_we_o,
    output logic [SELECT_WIDTH-1:0] wb_sel_o,
    output logic                    wb_stb_o,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    output logic                    wb_cyc_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value seen at the edge that closes the TIMEOUT-th strobe cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             timeout_hit;

    if (TIMEOUT > 0) begin : g_timeout
        assign timeout_hit = (cnt_reg == CNT_LAST);
    end else begin : g_no_timeout
        assign timeout_hit = 1'b0;
    end

    assign cmd_ready = (state_reg == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_sel_o    <= '0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        wb_adr_o  <= cmd_addr;
                        wb_dat_o  <= cmd_data;
                        wb_sel_o  <= cmd_sel;
                        wb_we_o   <= cmd_we;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= ST_BUS;
                    end
                end

                ST_BUS: begin
                    // A slave answer on the last allowed cycle beats the timeout; err beats ack.
                    if (wb_err_i) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        rsp_data    <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state_reg   <= ST_RESP;
                    end else if (wb_ack_i) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        rsp_data    <= wb_we_o ? '0 : wb_dat_i;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state_reg   <= ST_RESP;
                    end else if (timeout_hit) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        rsp_data    <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state_reg   <= ST_RESP;
                    end else if (cnt_reg != {CNT_W{1'b1}}) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end
                end

                default: begin
                    wb_cyc_o  <= 1'b0;
                    wb_stb_o  <= 1'b0;
                    rsp_valid <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_cmd.sv
// Bench for wb_master_cmd: bus slave with selectable behaviour, a transaction-level
// reference model checked every cycle, and directed transactions with literal expectations.
module tb_wb_master_cmd;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;
    localparam int TO = 8;

    localparam int M_RAM  = 0;
    localparam int M_ERR  = 1;
    localparam int M_NONE = 2;
    localparam int M_LATE = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic [SW-1:0] cmd_sel = '0;
    logic          cmd_we = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_we_o;
    logic [SW-1:0] wb_sel_o;
    logic          wb_stb_o;
    logic          wb_ack_i;
    logic          wb_err_i;
    logic          wb_cyc_o;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    wb_master_cmd #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_sel(cmd_sel), .cmd_we(cmd_we),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_cyc_o(wb_cyc_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- slave: RAM with a configurable answer cycle ----------------
    logic [31:0] smem [0:15];
    logic        s_ack = 1'b0;
    logic        s_err = 1'b0;
    logic [31:0] s_dat = 32'h5A5A_5A5A;
    int          s_cnt = 0;
    int          s_mode = M_RAM;

    assign wb_ack_i = s_ack;
    assign wb_err_i = s_err;
    assign wb_dat_i = s_dat;

    // Strobe cycle (1-based) during which the slave drives its answer.
    function automatic int resp_cycle(input int mode);
        if (mode == M_LATE) return 8;
        if (mode == M_NONE) return 0;
        return 2;
    endfunction

    function automatic logic [31:0] ram_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o && !s_ack) begin
            s_cnt <= s_cnt + 1;
            if (s_mode != M_NONE && s_cnt + 1 == resp_cycle(s_mode) - 1) begin
                s_ack <= 1'b1;
                s_err <= (s_mode == M_ERR);
                s_dat <= smem[wb_adr_o[5:2]];
            end
        end else begin
            if (s_ack && !s_err && wb_cyc_o && wb_we_o)
                smem[wb_adr_o[5:2]] <= ram_merge(smem[wb_adr_o[5:2]], wb_dat_o, wb_sel_o);
            s_ack <= 1'b0;
            s_err <= 1'b0;
            s_cnt <= 0;
        end
    end

    // ---------------- reference model, compared on every falling edge ----------------
    logic        m_ok = 1'b0;
    logic        m_cyc = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_err = 1'b0;
    logic        m_to = 1'b0;
    logic [31:0] m_data = '0;
    logic [15:0] m_adr = '0;
    logic [31:0] m_wdat = '0;
    logic [3:0]  m_sel = '0;
    logic        m_we = 1'b0;
    int          m_cnt = 0;
    logic [31:0] ref_mem [0:15];

    function automatic logic [31:0] sel_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) begin
            smem[i] = '0;
            ref_mem[i] = '0;
        end
        forever begin
            @(negedge clk);
            if (m_ok) begin
                chk("cmd_ready", 64'(cmd_ready), 64'(!m_cyc && !m_valid));
                chk("wb_cyc_o", 64'(wb_cyc_o), 64'(m_cyc));
                chk("wb_stb_o", 64'(wb_stb_o), 64'(m_cyc));
                chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
                chk("rsp_err", 64'(rsp_err), 64'(m_err));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(m_to));
                chk("rsp_data", 64'(rsp_data), 64'(m_data));
                if (m_cyc) begin
                    chk("wb_adr_o", 64'(wb_adr_o), 64'(m_adr));
                    chk("wb_dat_o", 64'(wb_dat_o), 64'(m_wdat));
                    chk("wb_sel_o", 64'(wb_sel_o), 64'(m_sel));
                    chk("wb_we_o", 64'(wb_we_o), 64'(m_we));
                end
            end
            // Advance the model to what must hold after the coming rising edge.
            if (!rst_n) begin
                m_cyc = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_to = 1'b0;
                m_data = '0; m_cnt = 0; m_ok = 1'b1;
            end else if (m_cyc) begin
                if (wb_err_i || wb_ack_i || m_cnt + 1 == TO) begin
                    m_cyc = 1'b0;
                    m_valid = 1'b1;
                    m_data = '0;
                    m_err = wb_err_i || !wb_ack_i;
                    m_to = !wb_err_i && !wb_ack_i;
                    if (wb_ack_i && !wb_err_i) begin
                        if (m_we)
                            ref_mem[m_adr[5:2]] = (ref_mem[m_adr[5:2]] & ~sel_mask(m_sel))
                                                | (m_wdat & sel_mask(m_sel));
                        else
                            m_data = ref_mem[m_adr[5:2]];
                    end
                end else begin
                    m_cnt++;
                end
            end else if (m_valid) begin
                if (rsp_ready) begin
                    m_valid = 1'b0; m_err = 1'b0; m_to = 1'b0;
                end
            end else if (cmd_valid) begin
                m_cyc = 1'b1; m_cnt = 0;
                m_adr = cmd_addr; m_wdat = cmd_data; m_sel = cmd_sel; m_we = cmd_we;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic we);
        logic ok;
        cmd_addr = a; cmd_data = d; cmd_sel = s; cmd_we = we; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        chk("cmd_accepted", 64'(ok), 64'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] d, output logic e, output logic t,
                            output int cyc_n);
        logic got;
        got = 1'b0;
        cyc_n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (wb_cyc_o) cyc_n++;
            if (rsp_valid) begin got = 1'b1; break; end
        end
        chk("rsp_arrived", 64'(got), 64'(1));
        d = rsp_data; e = rsp_err; t = rsp_timeout;
        @(posedge clk); #1;
    endtask

    task automatic txn(input string nm, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic we, input logic [31:0] exp_d,
                       input logic exp_e, input logic exp_t, input int exp_cyc);
        logic [31:0] rd;
        logic        re, rt;
        int          cn;
        issue(a, d, s, we);
        wait_rsp(rd, re, rt, cn);
        $display("txn %s adr=%h we=%b sel=%h rsp_data=%h err=%b timeout=%b cyc_cycles=%0d",
                 nm, a, we, s, rd, re, rt, cn);
        chk({nm, ".data"}, 64'(rd), 64'(exp_d));
        chk({nm, ".err"}, 64'(re), 64'(exp_e));
        chk({nm, ".timeout"}, 64'(rt), 64'(exp_t));
        chk({nm, ".cyc_cycles"}, 64'(cn), 64'(exp_cyc));
    endtask

    initial begin
        logic [31:0] rd;
        logic        re, rt;
        int          cn;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset.cmd_ready", 64'(cmd_ready), 64'(1));
        chk("reset.cyc", 64'(wb_cyc_o), 64'(0));
        chk("reset.rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset.rsp_data", 64'(rsp_data), 64'(0));
        @(posedge clk); #1;

        s_mode = M_RAM;
        txn("wr_full", 16'h0010, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0, 2);
        txn("rd_full", 16'h0010, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 2);
        txn("wr_init", 16'h0020, 32'h11223344, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0, 2);
        txn("wr_byte", 16'h0020, 32'h0000AB00, 4'b0010, 1'b1, 32'h0, 1'b0, 1'b0, 2);
        txn("rd_byte", 16'h0020, 32'h0, 4'hF, 1'b0, 32'h1122AB44, 1'b0, 1'b0, 2);

        s_mode = M_ERR;
        txn("rd_err", 16'h0010, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0, 2);

        s_mode = M_NONE;
        txn("rd_timeout", 16'h0010, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1, 1'b1, 8);

        s_mode = M_LATE;
        txn("rd_late_ack", 16'h0010, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 8);

        // Backpressure: hold the response, with a new command already waiting.
        s_mode = M_RAM;
        rsp_ready = 1'b0;
        issue(16'h0020, 32'h0, 4'hF, 1'b0);
        wait_rsp(rd, re, rt, cn);
        $display("txn bp_hold adr=0020 rsp_data=%h err=%b", rd, re);
        chk("bp.data", 64'(rd), 64'(32'h1122AB44));
        cmd_addr = 16'h0010; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.rsp_valid", 64'(rsp_valid), 64'(1));
            chk("bp.rsp_data", 64'(rsp_data), 64'(32'h1122AB44));
            chk("bp.cmd_ready", 64'(cmd_ready), 64'(0));
            chk("bp.cyc", 64'(wb_cyc_o), 64'(0));
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp.release_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("bp.release_rsp_valid", 64'(rsp_valid), 64'(0));
        @(posedge clk); #1 cmd_valid = 1'b0;
        wait_rsp(rd, re, rt, cn);
        $display("txn bp_next adr=0010 rsp_data=%h err=%b cyc_cycles=%0d", rd, re, cn);
        chk("bp_next.data", 64'(rd), 64'(32'hDEADBEEF));
        chk("bp_next.cyc_cycles", 64'(cn), 64'(2));

        // Reset while the bus cycle is open.
        s_mode = M_NONE;
        issue(16'h0010, 32'h0, 4'hF, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        $display("txn reset_mid_bus cyc=%b stb=%b rsp_valid=%b", wb_cyc_o, wb_stb_o, rsp_valid);
        chk("rst_mid.cyc", 64'(wb_cyc_o), 64'(0));
        chk("rst_mid.stb", 64'(wb_stb_o), 64'(0));
        chk("rst_mid.rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_mid.cmd_ready", 64'(cmd_ready), 64'(1));
        @(posedge clk); #1;
        s_mode = M_RAM;
        txn("rd_after_rst", 16'h0010, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 2);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/wb_master_cmd.md
Name: wb_master_cmd

Overview:
- Single-transaction Wishbone classic master driven by a valid/ready command stream; returns one response per command on a valid/ready response stream.
- Sits between a local controller (CPU bridge, test sequencer, config engine) and Wishbone slaves such as the team's RAM and register blocks.
- Adds a bus timeout so a non-responding slave cannot hang the initiator.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (8, 16, 32 or 64).
- ADDR_WIDTH, 16, address bus width in bits.
- SELECT_WIDTH, DATA_WIDTH/8, byte-select width.
- TIMEOUT, 255, max cycles stb may stay high awaiting ack/err; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- cmd_addr  in  ADDR_WIDTH  transaction address.
- cmd_data  in  DATA_WIDTH  write data.
- cmd_sel  in  SELECT_WIDTH  byte selects.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid & ready.
- rsp_data  out  DATA_WIDTH  read data (0 for writes/errors).
- rsp_err  out  1  slave err or timeout.
- rsp_timeout  out  1  timeout occurred (implies rsp_err).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when valid & ready.
- wb_adr_o  out  ADDR_WIDTH  ADR_O.
- wb_dat_o  out  DATA_WIDTH  DAT_O.
- wb_dat_i  in  DATA_WIDTH  DAT_I.
- wb_we_o  out  1  WE_O.
- wb_sel_o  out  SELECT_WIDTH  SEL_O.
- wb_stb_o  out  1  STB_O.
- wb_ack_i  in  1  ACK_I.
- wb_err_i  in  1  ERR_I.
- wb_cyc_o  out  1  CYC_O.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE.
- All registered outputs cleared to 0: cyc, stb, we, sel, adr, dat_o, rsp_data, rsp_err, rsp_timeout, rsp_valid.
- Timeout counter cleared.
- Reset mid-transaction aborts the bus cycle: cyc/stb low after that edge. Any pending response is discarded.
- cmd_ready = (state == IDLE); it is high in the first cycle after reset release.
- FSM IDLE: on cmd_valid & cmd_ready at edge N, register adr/dat/sel/we. Set cyc = stb = 1 from N+1. Clear the counter. Go to BUS.
- FSM BUS: adr/dat_o/sel/we are held stable; the counter increments each cycle.
  - At an edge with err_i = 1: rsp_err = 1, rsp_data = 0.
  - At an edge with ack_i = 1 and err_i = 0: rsp_data = wb_dat_i on reads, 0 on writes; rsp_err = 0.
  - Both ack and err at the same edge: err wins.
  - On ack or err, cyc/stb drop at that same edge, rsp_valid = 1, go to RESP.
- Timeout (TIMEOUT > 0):
  - If stb has been high TIMEOUT cycles with no ack/err, drop cyc/stb at the end of the TIMEOUT-th cycle.
  - Set rsp_err = rsp_timeout = 1 and rsp_data = 0; go to RESP.
  - ack/err sampled on that final cycle takes precedence over timeout.
  - Counter width is $clog2(TIMEOUT+1); it never wraps.
- FSM RESP: rsp_* held stable while rsp_valid & ~rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid = 0, rsp_err = rsp_timeout = 0, go to IDLE.
  - rsp_data holds its last value.
- ack_i/err_i seen outside BUS are ignored.
- Wishbone outputs outside a cycle hold their last values; only cyc/stb are meaningful there.
- Latency:
  - Slave acking one cycle after stb: command accepted at edge N, ack at N+2, rsp_valid high from N+2.
  - With rsp_ready held high, the next command is accepted at N+4; throughput is 1 transaction per 4 cycles.
- No pipelining or bursts; one outstanding transaction only.

Test Plan:
- Write then read vs. the team RAM model: write 0xDEADBEEF to 0x0010 with sel=4'hF, then read 0x0010 -> write rsp_data=0, rsp_err=0; read rsp_data=0xDEADBEEF; cyc high exactly 2 cycles per transaction.
- Byte-select write: sel=4'b0010 with data 0x0000AB00 onto a location holding 0x11223344 -> read returns 0x1122AB44; wb_sel_o=4'b0010 throughout the write cycle.
- Slave asserts err_i (and ack_i simultaneously) on a read -> rsp_err=1, rsp_timeout=0, rsp_data=0; cyc drops the same edge.
- No responding slave, TIMEOUT=8 -> stb high exactly 8 cycles, then rsp_err=1, rsp_timeout=1; ack arriving on cycle 8 instead gives rsp_err=0.
- Backpressure: rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, no new cyc; rsp_ready high -> cmd_ready=1 on the next cycle.
- Reset asserted during BUS with stb high -> cyc=stb=0 and rsp_valid=0 after the reset edge; first command after release completes normally.
